// File: rtl/qpu_exu_oitf_ctrl.sv
// Outstanding Instruction Track FIFO for the long pipe: allocates at dispatch,
// retires in order at write-back, and flags RAW/WAW hazards against in-flight entries.
module qpu_exu_oitf_ctrl #(
  parameter int OITF_DEPTH = 4,
  parameter int RFIDX_W    = 5,
  parameter int PTR_W      = $clog2(OITF_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dis_ena,
  output logic               dis_ready,
  input  logic               disp_i_rdwen,
  input  logic [RFIDX_W-1:0] disp_i_rdidx,
  input  logic               disp_i_rs1en,
  input  logic [RFIDX_W-1:0] disp_i_rs1idx,
  input  logic               disp_i_rs2en,
  input  logic [RFIDX_W-1:0] disp_i_rs2idx,
  output logic [PTR_W-1:0]   dis_ptr,
  input  logic               ret_ena,
  output logic [PTR_W-1:0]   ret_ptr,
  output logic [RFIDX_W-1:0] ret_rdidx,
  output logic               ret_rdwen,
  output logic               oitfrd_match_disprs1,
  output logic               oitfrd_match_disprs2,
  output logic               oitfrd_match_disprd,
  output logic               oitf_empty,
  output logic [PTR_W:0]     oitf_cnt
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry the wrap flag as their MSB so full/empty/count fall out of plain arithmetic.
  logic [PTR_W:0]       wptr_q, wptr_d;
  logic [PTR_W:0]       rptr_q, rptr_d;
  logic [OITF_DEPTH-1:0] valid_q;
  logic [OITF_DEPTH-1:0] rdwen_q;
  logic [RFIDX_W-1:0]   rdidx_q [OITF_DEPTH];

  logic full;
  logic empty;
  logic alloc_fire;
  logic ret_fire;

  assign full  = (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]) && (wptr_q[PTR_W] != rptr_q[PTR_W]);
  assign empty = (wptr_q == rptr_q);

  assign alloc_fire = dis_ena & ~full;
  assign ret_fire   = ret_ena & ~empty;

  assign wptr_d = alloc_fire ? (wptr_q + PTR_ONE) : wptr_q;
  assign rptr_d = ret_fire   ? (rptr_q + PTR_ONE) : rptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= '0;
      rdwen_q <= '0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        rdidx_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      // Allocate and retire slots never coincide: equal pointers mean full (no
      // allocate) or empty (no retire).
      if (ret_fire) begin
        valid_q[rptr_q[PTR_W-1:0]] <= 1'b0;
      end
      if (alloc_fire) begin
        valid_q[wptr_q[PTR_W-1:0]] <= 1'b1;
        rdwen_q[wptr_q[PTR_W-1:0]] <= disp_i_rdwen;
        rdidx_q[wptr_q[PTR_W-1:0]] <= disp_i_rdidx;
      end
    end
  end

  assign dis_ready  = ~full;
  assign oitf_empty = empty;
  assign oitf_cnt   = wptr_q - rptr_q;
  assign dis_ptr    = wptr_q[PTR_W-1:0];
  assign ret_ptr    = rptr_q[PTR_W-1:0];

  assign ret_rdidx = rdidx_q[rptr_q[PTR_W-1:0]];
  assign ret_rdwen = valid_q[rptr_q[PTR_W-1:0]] & rdwen_q[rptr_q[PTR_W-1:0]];

  logic hit_rs1;
  logic hit_rs2;
  logic hit_rd;

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (valid_q[i] && rdwen_q[i]) begin
        if (rdidx_q[i] == disp_i_rs1idx) hit_rs1 = 1'b1;
        if (rdidx_q[i] == disp_i_rs2idx) hit_rs2 = 1'b1;
        if (rdidx_q[i] == disp_i_rdidx)  hit_rd  = 1'b1;
      end
    end
  end

  assign oitfrd_match_disprs1 = hit_rs1 & disp_i_rs1en;
  assign oitfrd_match_disprs2 = hit_rs2 & disp_i_rs2en;
  assign oitfrd_match_disprd  = hit_rd  & disp_i_rdwen;

endmodule

// File: doc/qpu_exu_oitf_ctrl.md
Name: qpu_exu_oitf_ctrl

Overview:
- Outstanding Instruction Track FIFO controller for the long pipe.
- Allocates one entry per long-pipe instruction at dispatch and retires entries in order when the long-pipe write-back arbiter accepts a result.
- Presents the head entry's destination (ret_rdidx/ret_rdwen) to that arbiter.
- Reports RAW/WAW hazards of the dispatching instruction against all in-flight entries, so dispatch can stall.

Parameters:
- OITF_DEPTH, 4, number of entries; power of two, minimum 2.
- RFIDX_W, 5, register index width (equals QPU_RFIDX_REAL_WIDTH).
- PTR_W, log2(OITF_DEPTH), entry pointer width (derived).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- dis_ena  in  1  allocate an entry this cycle (long-pipe instruction dispatched).
- dis_ready  out  1  FIFO not full; allocation allowed.
- disp_i_rdwen  in  1  dispatching instruction writes a register.
- disp_i_rdidx  in  RFIDX_W  its destination index.
- disp_i_rs1en  in  1  rs1 read valid.
- disp_i_rs1idx  in  RFIDX_W  rs1 index.
- disp_i_rs2en  in  1  rs2 read valid.
- disp_i_rs2idx  in  RFIDX_W  rs2 index.
- dis_ptr  out  PTR_W  index of the entry that dis_ena allocates (write pointer).
- ret_ena  in  1  retire head entry (driven by oitf_ret_ena of long-pipe wbck).
- ret_ptr  out  PTR_W  head entry index (read pointer).
- ret_rdidx  out  RFIDX_W  head entry rd index.
- ret_rdwen  out  1  head entry valid AND rdwen.
- oitfrd_match_disprs1  out  1  RAW hazard on rs1.
- oitfrd_match_disprs2  out  1  RAW hazard on rs2.
- oitfrd_match_disprd  out  1  WAW hazard on rd.
- oitf_empty  out  1  no valid entries.
- oitf_cnt  out  PTR_W+1  number of valid entries, 0..OITF_DEPTH.

Behaviour:
- Storage: per entry, a valid bit, rdwen and rdidx. Write pointer and read pointer are PTR_W bits, each with a wrap flag that toggles when the pointer passes OITF_DEPTH-1 -> 0.
- Full: pointers equal and wrap flags differ. Empty: pointers equal and wrap flags equal.
- Reset (rst=1 at clock edge): pointers, wrap flags, all valid/rdwen/rdidx cleared to 0. Resulting outputs: dis_ready=1, oitf_empty=1, oitf_cnt=0, ret_rdwen=0, ret_rdidx=0, all match outputs=0, dis_ptr=ret_ptr=0. Reset overrides simultaneous dis_ena/ret_ena.
- Allocate: when dis_ena & dis_ready, the entry at dis_ptr gets valid=1, rdwen=disp_i_rdwen, rdidx=disp_i_rdidx. Write pointer then increments.
- dis_ena while full is ignored with no state change. The bench flags this as a protocol error.
- Retire: when ret_ena & ~oitf_empty, the entry at ret_ptr gets valid=0 and the read pointer increments.
- ret_ena while empty is ignored with no state change.
- Simultaneous allocate and retire:
  - Both occur; oitf_cnt is unchanged.
  - When full, dis_ready=0 in that cycle, so only the retire occurs.
  - When empty, only the allocate occurs. A new entry is never retired in its allocation cycle.
- Head outputs are combinational from the entry at ret_ptr: ret_rdidx = entry rdidx; ret_rdwen = entry valid & entry rdwen.
- Latency:
  - Allocation is visible on the head outputs and match outputs the cycle after dis_ena.
  - A retired entry still contributes to the match outputs during its ret_ena cycle and stops the next cycle.
- Matches are combinational:
  - oitfrd_match_disprs1 = OR over entries of (valid & rdwen & rdidx==disp_i_rs1idx) & disp_i_rs1en.
  - oitfrd_match_disprs2 is the same using rs2.
  - oitfrd_match_disprd is the same using disp_i_rdidx, gated by disp_i_rdwen.
- Index 0 is compared like any other index; no special case for x0.
- dis_ready = ~full. oitf_empty and oitf_cnt are derived from the pointers and wrap flags: cnt = wptr - rptr (mod 2*OITF_DEPTH including the wrap bit).
- Pointer wrap: after OITF_DEPTH allocations from reset, dis_ptr returns to 0 and the wrap flag is 1. Full/empty are computed correctly across any number of wraps.

Test Plan:
- Reset then idle -> dis_ready=1, oitf_empty=1, oitf_cnt=0, ret_rdwen=0, all matches 0.
- Fill: 4 back-to-back dis_ena with rdidx 3,5,7,9 and rdwen=1:
  - Expect dis_ptr 0,1,2,3; then dis_ready=0 and oitf_cnt=4.
  - A 5th dis_ena changes nothing.
  - ret_rdidx=3.
- Hazards with entries {3,5} in flight:
  - rs1idx=5, rs1en=1 -> match_disprs1=1.
  - rs1en=0 -> 0.
  - rdidx=3, rdwen=1 -> match_disprd=1.
  - rs2idx=6 -> match_disprs2=0.
- In-order retire: retire 4 entries in successive cycles:
  - ret_rdidx sequence 3,5,7,9.
  - Match on 3 persists during its retire cycle and clears the next cycle.
  - oitf_empty=1 at the end.
- Simultaneous ops:
  - With cnt=2, assert dis_ena and ret_ena together -> cnt stays 2, ret_ptr and dis_ptr both advance.
  - With cnt=4, assert both -> only retire occurs, cnt=3.
  - With cnt=0, assert both -> only allocate occurs, cnt=1.
- Wrap and reset: 10 allocate/retire pairs to cross the wrap twice, then full/empty are checked. Then rst=1 together with dis_ena=1 -> all state 0, and no entry is allocated.
